wb_txn_master: RTL and testbench

Synthesizable Wishbone B3 classic master that drives the SDRAM controller's Wishbone slave port (wb_*_i side) from a simple command/data stream. It sits directly upstream of the controller and of the whitebox protocol checker. Its outputs are built to satisfy reset rules 3.00/3.05/3.10, initiation rule 3.25 and termination rule 3.35 by construction. Supports single and incrementing-burst reads and writes, with an ack timeout.

---
 rtl/wb_txn_master_if.sv | 27 ++
 rtl/wb_txn_master.sv | 199 +++++++++++++++++++
 tb/tb_wb_txn_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_txn_master_if.sv
// Wishbone B3 classic bus between wb_txn_master and the SDRAM controller slave port.
// Signal names follow the master's view so existing wiring carries over unchanged.
interface wb_txn_master_if #(
  parameter int AW = 26,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_txn_master.sv
// Wishbone B3 classic master: turns a command/data stream into single or incrementing
// burst transfers, with registered bus outputs and an ack timeout that aborts the cycle.
module wb_txn_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DW-1:0]     wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              err_timeout,
  output logic              busy,
  wb_txn_master_if.master   wb
);
  localparam int SW = DW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BEAT, WAIT_DATA, DONE} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DW-1:0]     rdat_q, rdat_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              wr_rdy_c;
  logic              last_beat;

  // Beat counter only advances on non-final beats, so len = all-ones never overflows.
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    rdat_d   = rdat_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    err_d    = 1'b0;
    busy_d   = busy_q;
    wr_rdy_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d   = cmd_we;
          adr_d  = cmd_addr & ~AW'(SW - 1);
          sel_d  = cmd_sel;
          len_d  = cmd_len;
          cnt_d  = '0;
          tmo_d  = '0;
          cyc_d  = 1'b1;
          busy_d = 1'b1;
          if (!cmd_we) begin
            stb_d   = 1'b1;
            state_d = BEAT;
          end else begin
            wr_rdy_c = 1'b1;
            if (wr_valid) begin
              dat_d   = wr_data;
              stb_d   = 1'b1;
              state_d = BEAT;
            end else begin
              state_d = WAIT_DATA;
            end
          end
        end
      end

      BEAT: begin
        if (wb.wb_ack_i) begin
          tmo_d = '0;
          if (!we_q) begin
            rdat_d   = wb.wb_dat_i;
            rvalid_d = 1'b1;
            rlast_d  = last_beat;
          end
          if (last_beat) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            adr_d = adr_q + AW'(SW);
            cnt_d = cnt_q + LEN_W'(1);
            if (we_q) begin
              wr_rdy_c = 1'b1;
              if (wr_valid) begin
                dat_d = wr_data;
              end else begin
                stb_d   = 1'b0;
                state_d = WAIT_DATA;
              end
            end
          end
        end else if (tmo_q == TW'(TIMEOUT)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      WAIT_DATA: begin
        wr_rdy_c = 1'b1;
        if (wr_valid) begin
          dat_d   = wr_data;
          stb_d   = 1'b1;
          state_d = BEAT;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      rdat_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rdat_q   <= rdat_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE) && !wb_rst_i;
  assign wr_ready    = wr_rdy_c && !wb_rst_i;
  assign rd_data     = rdat_q;
  assign rd_valid    = rvalid_q;
  assign rd_last     = rlast_q;
  assign err_timeout = err_q;
  assign busy        = busy_q;

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
endmodule

// File: tb/tb_wb_txn_master.sv
// Bench for wb_txn_master: cycle-vector table, directed corner sequences and a
// randomized run against a beat-list reference model with a behavioural slave.
module tb_wb_txn_master;
  localparam int AW = 26, DW = 32, SW = 4, LEN_W = 8, TMO = 8;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [SW-1:0]    cmd_sel;
  logic [LEN_W-1:0] cmd_len;
  logic [DW-1:0]    wr_data, rd_data;
  logic             wr_valid, wr_ready, rd_valid, rd_last, err_timeout, busy;

  wb_txn_master_if #(.AW(AW), .DW(DW)) wbif ();

  wb_txn_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .err_timeout(err_timeout), .busy(busy),
    .wb(wbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Environment state
  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } wbeat_t;

  logic [32:0]   rd_log[$];    // {last, data}
  logic [AW-1:0] radr_log[$];
  wbeat_t        wlog[$];
  logic [31:0]   feed_q[$];
  bit            slave_auto, feed_en, spurious, hs_c;
  int            slave_lat, wait_cnt, err_seen, proto_viol;
  logic [31:0]   rd_offset;

  function automatic logic [31:0] rd_fn(input logic [AW-1:0] a);
    return {8'h00, a[AW-1:2]} + rd_offset;
  endfunction

  task automatic clear_logs();
    rd_log.delete(); radr_log.delete(); wlog.delete();
  endtask

  // One clock: sample on the falling edge, then update slave/feeder just after the rising edge.
  task automatic step();
    bit hs_w;
    wbeat_t b;
    @(negedge clk);
    if (rd_valid) rd_log.push_back({rd_last, rd_data});
    if (err_timeout) err_seen++;
    if (wbif.wb_stb_o && !wbif.wb_cyc_o) proto_viol++;
    if (wbif.wb_ack_i && wbif.wb_stb_o) begin
      if (wbif.wb_we_o) begin
        b.adr = wbif.wb_adr_o; b.dat = wbif.wb_dat_o; b.sel = wbif.wb_sel_o;
        wlog.push_back(b);
      end else radr_log.push_back(wbif.wb_adr_o);
    end
    hs_w = wr_valid && wr_ready;
    hs_c = cmd_valid && cmd_ready;
    @(posedge clk); #1;
    if (feed_en) begin
      if (hs_w && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() > 0 && $urandom_range(3) != 0) begin
        wr_valid = 1'b1; wr_data = feed_q[0];
      end else wr_valid = 1'b0;
    end
    if (slave_auto) begin
      if (wbif.wb_stb_o) begin
        if (slave_lat >= 0 && wait_cnt >= slave_lat) begin
          wbif.wb_ack_i = 1'b1; wbif.wb_dat_i = rd_fn(wbif.wb_adr_o); wait_cnt = 0;
        end else begin
          wbif.wb_ack_i = 1'b0; wait_cnt++;
        end
      end else begin
        wbif.wb_ack_i = spurious && ($urandom_range(1) == 1);
        wbif.wb_dat_i = $urandom;
        wait_cnt = 0;
      end
    end
  endtask

  // Cycle-vector table: in = {rst,cmd_valid,cmd_we,wr_valid,ack};
  // ex = {cmd_ready_pre, wr_ready_pre, cmd_ready, cyc, stb, we, busy}; bus fields checked when cb.
  typedef struct {
    bit [4:0]      in;
    bit [6:0]      ex;
    bit            cb;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [AW-1:0] base, ea;
    logic [31:0]   exp_w[$];
    int            n, len, err0, rdl0;
    bit            we;

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_sel = '0;
    cmd_len = '0; wr_data = '0; wr_valid = 1'b0;
    wbif.wb_ack_i = 1'b0; wbif.wb_dat_i = '0;
    slave_auto = 0; feed_en = 0; spurious = 0; slave_lat = 0; wait_cnt = 0;
    err_seen = 0; proto_viol = 0; rd_offset = '0;

    // ---- Reset hold and single write with ack after 4 cycles ----
    tbl[0] = '{5'b11110, 7'b0000000, 1'b1, 26'h0,   32'h0,        4'h0};
    tbl[1] = '{5'b11110, 7'b0000000, 1'b1, 26'h0,   32'h0,        4'h0};
    tbl[2] = '{5'b11110, 7'b0000000, 1'b1, 26'h0,   32'h0,        4'h0};
    tbl[3] = '{5'b00000, 7'b1010000, 1'b1, 26'h0,   32'h0,        4'h0};
    tbl[4] = '{5'b01110, 7'b1101111, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF};
    tbl[5] = '{5'b00000, 7'b0001111, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF};
    tbl[6] = '{5'b00000, 7'b0001111, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF};
    tbl[7] = '{5'b00000, 7'b0001111, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF};
    tbl[8] = '{5'b00001, 7'b0000000, 1'b0, 26'h0,   32'h0,        4'h0};
    tbl[9] = '{5'b00000, 7'b0010000, 1'b0, 26'h0,   32'h0,        4'h0};

    cmd_addr = 26'h100; cmd_sel = 4'hF; cmd_len = '0; wr_data = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      {rst, cmd_valid, cmd_we, wr_valid, wbif.wb_ack_i} = tbl[i].in;
      #1;
      chk($sformatf("vec%0d_cmd_ready_pre", i), cmd_ready, tbl[i].ex[6]);
      chk($sformatf("vec%0d_wr_ready_pre", i), wr_ready, tbl[i].ex[5]);
      step();
      chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, tbl[i].ex[4]);
      chk($sformatf("vec%0d_cyc", i), wbif.wb_cyc_o, tbl[i].ex[3]);
      chk($sformatf("vec%0d_stb", i), wbif.wb_stb_o, tbl[i].ex[2]);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].ex[0]);
      if (tbl[i].cb) begin
        chk($sformatf("vec%0d_we", i), wbif.wb_we_o, tbl[i].ex[1]);
        chk($sformatf("vec%0d_adr", i), wbif.wb_adr_o, tbl[i].adr);
        chk($sformatf("vec%0d_dat", i), wbif.wb_dat_o, tbl[i].dat);
        chk($sformatf("vec%0d_sel", i), wbif.wb_sel_o, tbl[i].sel);
      end
    end

    // ---- Read burst, len=3, continuous ack ----
    slave_auto = 1; slave_lat = 0; spurious = 0; rd_offset = 32'h90;
    wbif.wb_ack_i = 1'b0; clear_logs();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h40; cmd_len = 8'd3; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    chk("rdb_stb_latency", {wbif.wb_cyc_o, wbif.wb_stb_o}, 2'b11);
    n = 0;
    while (wbif.wb_cyc_o && n < 50) begin step(); n++; end
    chk("rdb_cycles", n, 4);
    step();
    chk("rdb_nadr", radr_log.size(), 4);
    chk("rdb_nrd", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < radr_log.size()) chk($sformatf("rdb_adr%0d", i), radr_log[i], 26'h40 + 26'(4 * i));
      if (i < rd_log.size())   chk($sformatf("rdb_rd%0d", i), rd_log[i], {(i == 3), 32'hA0 + 32'(i)});
    end

    // ---- Write burst, len=1, data withheld 5 cycles before beat 2 ----
    clear_logs(); err0 = err_seen;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 26'h200; cmd_len = 8'd1; cmd_sel = 4'h3;
    wr_valid = 1'b1; wr_data = 32'h11112222;
    step();
    cmd_valid = 1'b0; wr_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("gap%0d_cyc_stb", k), {wbif.wb_cyc_o, wbif.wb_stb_o}, 2'b10);
      step();
    end
    wr_valid = 1'b1; wr_data = 32'h33334444;
    step();
    wr_valid = 1'b0;
    chk("gap_beat2_dat", wbif.wb_dat_o, 32'h33334444);
    chk("gap_beat2_stb", wbif.wb_stb_o, 1'b1);
    step();
    chk("gap_done_cyc", wbif.wb_cyc_o, 1'b0);
    step();
    chk("gap_nbeats", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("gap_adr0", wlog[0].adr, 26'h200);
      chk("gap_dat0", wlog[0].dat, 32'h11112222);
      chk("gap_adr1", wlog[1].adr, 26'h204);
      chk("gap_dat1", wlog[1].dat, 32'h33334444);
      chk("gap_sel1", wlog[1].sel, 4'h3);
    end
    chk("gap_no_timeout", err_seen - err0, 0);

    // ---- Slave never acks: timeout abort ----
    clear_logs(); slave_lat = -1; err0 = err_seen;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h300; cmd_len = 8'd2;
    step();
    cmd_valid = 1'b0;
    chk("tmo_stb_rise", wbif.wb_stb_o, 1'b1);
    n = 0;
    while (!err_timeout && n < 40) begin step(); n++; end
    chk("tmo_latency", n, TMO + 1);
    chk("tmo_cyc_stb", {wbif.wb_cyc_o, wbif.wb_stb_o}, 2'b00);
    chk("tmo_cmd_ready", cmd_ready, 1'b1);
    step();
    chk("tmo_pulse_width", err_timeout, 1'b0);
    chk("tmo_cmd_ready_next", cmd_ready, 1'b1);
    chk("tmo_pulse_count", err_seen - err0, 1);
    chk("tmo_no_rd", rd_log.size(), 0);

    // ---- Reset during beat 2 of a 4-beat read ----
    clear_logs(); slave_lat = 0; err0 = err_seen;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h400; cmd_len = 8'd3;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_cyc_stb", {wbif.wb_cyc_o, wbif.wb_stb_o}, 2'b00);
    chk("rst_mid_rd_valid", rd_valid, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b0);
    rdl0 = rd_log.size();
    chk("rst_mid_rd_before", rdl0, 1);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("rst_mid_rd_after", rd_log.size(), rdl0);
    chk("rst_mid_no_err", err_seen - err0, 0);
    chk("rst_mid_idle", {cmd_ready, wbif.wb_cyc_o, busy}, 3'b100);

    // ---- Randomized transactions vs reference beat list ----
    feed_en = 1; spurious = 1;
    for (int t = 0; t < 24; t++) begin
      we  = ($urandom_range(1) == 1);
      len = $urandom_range(5);
      cmd_addr = AW'($urandom);
      if (t == 0) begin we = 1; len = 3;   cmd_addr = 26'h3FFFFF9; end
      if (t == 1) begin we = 0; len = 255; end
      if (t == 2) begin we = 0; len = 2;   cmd_addr = 26'h3FFFFFC; end
      cmd_we = we; cmd_len = LEN_W'(len); cmd_sel = SW'($urandom_range(15));
      slave_lat = $urandom_range(3); rd_offset = $urandom;
      clear_logs(); feed_q.delete(); exp_w.delete(); err0 = err_seen;
      if (we) for (int i = 0; i <= len; i++) begin
        exp_w.push_back($urandom); feed_q.push_back(exp_w[i]);
      end
      base = cmd_addr & ~AW'(3);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk($sformatf("rnd%0d_accept", t), hs_c, 1'b1);
      n = 0;
      while ((wbif.wb_cyc_o || busy) && n < 2000) begin step(); n++; end
      chk($sformatf("rnd%0d_complete", t), wbif.wb_cyc_o, 1'b0);
      step();
      if (we) begin
        chk($sformatf("rnd%0d_nbeats", t), wlog.size(), len + 1);
        chk($sformatf("rnd%0d_feed_drained", t), feed_q.size(), 0);
        for (int i = 0; i <= len && i < wlog.size(); i++) begin
          ea = base + AW'(4 * i);
          chk($sformatf("rnd%0d_wadr%0d", t, i), wlog[i].adr, ea);
          chk($sformatf("rnd%0d_wdat%0d", t, i), wlog[i].dat, exp_w[i]);
          chk($sformatf("rnd%0d_wsel%0d", t, i), wlog[i].sel, cmd_sel);
        end
        chk($sformatf("rnd%0d_no_rd", t), rd_log.size(), 0);
      end else begin
        chk($sformatf("rnd%0d_nadr", t), radr_log.size(), len + 1);
        chk($sformatf("rnd%0d_nrd", t), rd_log.size(), len + 1);
        for (int i = 0; i <= len && i < rd_log.size() && i < radr_log.size(); i++) begin
          ea = base + AW'(4 * i);
          chk($sformatf("rnd%0d_radr%0d", t, i), radr_log[i], ea);
          chk($sformatf("rnd%0d_rd%0d", t, i), rd_log[i], {(i == len), rd_fn(ea)});
        end
      end
      chk($sformatf("rnd%0d_no_err", t), err_seen - err0, 0);
    end
    feed_en = 0; spurious = 0; wr_valid = 1'b0;

    chk("stb_without_cyc", proto_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
